// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, requester indices, last_served encoding.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t REQ_HOST  = 2'd0;
  localparam req_idx_t REQ_FETCH = 2'd1;
  localparam req_idx_t REQ_DATA  = 2'd2;

  localparam logic LS_FETCH = 1'b0;
  localparam logic LS_DATA  = 1'b1;

  function automatic logic [2:0] idx_onehot(input req_idx_t idx);
    logic [2:0] oh;
    oh = 3'b000;
    case (idx)
      REQ_HOST:  oh = 3'b001;
      REQ_FETCH: oh = 3'b010;
      REQ_DATA:  oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection: host strictly first, fetch/data round-robin, host lock holds others off.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic       host_lock,
  input  logic       lock_owner,
  input  logic       last_served,
  output logic       vld,
  output req_idx_t   winner
);

  always_comb begin
    vld    = 1'b0;
    winner = REQ_HOST;
    if (req[REQ_HOST]) begin
      vld    = 1'b1;
      winner = REQ_HOST;
    end else if (host_lock && lock_owner) begin
      // Host owns the memory between its locked accesses.
      vld = 1'b0;
    end else if (req[REQ_FETCH] && req[REQ_DATA]) begin
      vld    = 1'b1;
      winner = (last_served == LS_DATA) ? REQ_FETCH : REQ_DATA;
    end else if (req[REQ_FETCH]) begin
      vld    = 1'b1;
      winner = REQ_FETCH;
    end else if (req[REQ_DATA]) begin
      vld    = 1'b1;
      winner = REQ_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between host, fetch and data ports; one access per ACCESS cycle,
// ack in the following DONE cycle, back-to-back accesses every 2 cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic              fetch_req,
  input  logic              data_req,
  input  logic              host_we,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic              host_lock,
  output logic              host_ack,
  output logic              fetch_ack,
  output logic              data_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state, state_nxt;
  req_idx_t          lat_idx;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              host_owns;
  logic              last_served;
  logic [2:0]        req_vec, req_masked;
  logic              pick_vld;
  req_idx_t          pick_idx;
  logic              take;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  assign req_vec = {data_req, fetch_req, host_req};

  // The requester being acked still holds req during DONE, so hide it from re-arbitration.
  always_comb begin
    req_masked = req_vec;
    if (state == DONE) req_masked = req_vec & ~idx_onehot(lat_idx);
  end

  arb_pick u_pick (
    .req         (req_masked),
    .host_lock   (host_lock),
    .lock_owner  (host_owns),
    .last_served (last_served),
    .vld         (pick_vld),
    .winner      (pick_idx)
  );

  always_comb begin
    sel_addr  = host_addr;
    sel_wdata = host_wdata;
    sel_we    = host_we;
    case (pick_idx)
      REQ_FETCH: begin
        sel_addr  = fetch_addr;
        sel_wdata = '0;
        sel_we    = 1'b0;
      end
      REQ_DATA: begin
        sel_addr  = data_addr;
        sel_wdata = data_wdata;
        sel_we    = data_we;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = ACCESS;
          take      = 1'b1;
        end
      end
      ACCESS: state_nxt = DONE;
      DONE: begin
        if (pick_vld) begin
          state_nxt = ACCESS;
          take      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_idx     <= REQ_HOST;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_we      <= 1'b0;
      host_owns   <= 1'b0;
      last_served <= LS_DATA;
      rdata       <= '0;
    end else begin
      if (take) begin
        lat_idx   <= pick_idx;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        lat_we    <= sel_we;
        host_owns <= (pick_idx == REQ_HOST);
        if (pick_idx != REQ_HOST) last_served <= (pick_idx == REQ_DATA) ? LS_DATA : LS_FETCH;
      end
      if (state == ACCESS) rdata <= mem_rdata;
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_we    = (state == ACCESS) && lat_we;
  assign host_ack  = (state == DONE) && (lat_idx == REQ_HOST);
  assign fetch_ack = (state == DONE) && (lat_idx == REQ_FETCH);
  assign data_ack  = (state == DONE) && (lat_idx == REQ_DATA);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256-byte memory behind it.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_req, fetch_req, data_req;
  logic       host_we, data_we;
  logic [7:0] host_addr, fetch_addr, data_addr;
  logic [7:0] host_wdata, data_wdata;
  logic       host_lock;
  logic       host_ack, fetch_ack, data_ack;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, busy;

  logic [7:0] mem [0:255] = '{8'h10: 8'h5A, default: 8'h00};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_req   (host_req),
    .fetch_req  (fetch_req),
    .data_req   (data_req),
    .host_we    (host_we),
    .data_we    (data_we),
    .host_addr  (host_addr),
    .fetch_addr (fetch_addr),
    .data_addr  (data_addr),
    .host_wdata (host_wdata),
    .data_wdata (data_wdata),
    .host_lock  (host_lock),
    .host_ack   (host_ack),
    .fetch_ack  (fetch_ack),
    .data_ack   (data_ack),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] acks();
    return {data_ack, fetch_ack, host_ack};
  endfunction

  initial begin
    reset = 1'b0;
    {host_req, fetch_req, data_req, host_we, data_we, host_lock} = '0;
    {host_addr, fetch_addr, data_addr, host_wdata, data_wdata} = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_acks", acks(), 0);
    reset = 1'b1;
    step();
    step();

    // Single fetch read of 0x10
    fetch_req = 1; fetch_addr = 8'h10;
    step();
    chk("f1_busy", busy, 1);
    chk("f1_we", mem_we, 0);
    chk("f1_addr", mem_addr, 8'h10);
    chk("f1_noack", acks(), 0);
    step();
    chk("f1_ack", acks(), 3'b010);
    chk("f1_rdata", rdata, 8'h5A);
    fetch_req = 0;
    step();
    chk("f1_idle", busy, 0);
    chk("f1_ackoff", acks(), 0);

    // Data write 0x20 <= 0xC3, then read back
    data_req = 1; data_we = 1; data_addr = 8'h20; data_wdata = 8'hC3;
    step();
    chk("dw_we", mem_we, 1);
    chk("dw_addr", mem_addr, 8'h20);
    chk("dw_wdata", mem_wdata, 8'hC3);
    step();
    chk("dw_we_off", mem_we, 0);
    chk("dw_ack", acks(), 3'b100);
    data_req = 0; data_we = 0;
    step();
    data_req = 1;
    step();
    chk("dr_we", mem_we, 0);
    step();
    chk("dr_ack", acks(), 3'b100);
    chk("dr_rdata", rdata, 8'hC3);
    data_req = 0;
    step();

    // All three together: host write 0x30, fetch 0x10, data 0x20
    host_req = 1; host_we = 1; host_addr = 8'h30; host_wdata = 8'h11;
    fetch_req = 1; data_req = 1;
    step();
    chk("all_h_addr", mem_addr, 8'h30);
    chk("all_h_we", mem_we, 1);
    step();
    chk("all_h_ack", acks(), 3'b001);
    host_req = 0; host_we = 0;
    step();
    chk("all_f_addr", mem_addr, 8'h10);
    step();
    chk("all_f_ack", acks(), 3'b010);
    chk("all_f_rdata", rdata, 8'h5A);
    fetch_req = 0;
    step();
    chk("all_d_addr", mem_addr, 8'h20);
    step();
    chk("all_d_ack", acks(), 3'b100);
    chk("all_d_rdata", rdata, 8'hC3);
    data_req = 0;
    step();
    chk("all_idle", busy, 0);

    // Fetch and data held together: strict alternation, fetch first
    fetch_req = 1; data_req = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_access", acks(), 0);
      step();
      chk("rr_ack", acks(), (i % 2 == 0) ? 3'b010 : 3'b100);
    end
    fetch_req = 0; data_req = 0;
    step();
    chk("rr_idle", busy, 0);

    // Locked host burst of three writes with fetch pending
    host_lock = 1; fetch_req = 1; fetch_addr = 8'h10;
    for (int k = 0; k < 3; k++) begin
      host_req = 1; host_we = 1; host_addr = 8'h40 + 8'(k); host_wdata = 8'hA0 + 8'(k);
      step();
      chk("lk_addr", mem_addr, 8'h40 + 8'(k));
      chk("lk_we", mem_we, 1);
      step();
      chk("lk_ack", acks(), 3'b001);
      host_req = 0; host_we = 0;
      step();
      chk("lk_held", busy, 0);
    end
    host_lock = 0;
    step();
    chk("lk_f_addr", mem_addr, 8'h10);
    step();
    chk("lk_f_ack", acks(), 3'b010);
    fetch_req = 0;
    step();

    // Host read back of a locked write
    host_req = 1; host_addr = 8'h42;
    step();
    step();
    chk("hr_ack", acks(), 3'b001);
    chk("hr_rdata", rdata, 8'hA2);
    host_req = 0;
    step();

    // Reset during the ACCESS cycle of a write
    host_req = 1; host_we = 1; host_addr = 8'h50; host_wdata = 8'h77;
    step();
    chk("rm_we_pre", mem_we, 1);
    #2 reset = 1'b0;
    #1;
    chk("rm_we", mem_we, 0);
    chk("rm_busy", busy, 0);
    chk("rm_acks", acks(), 0);
    host_req = 0; host_we = 0;
    step();
    chk("rm_acks2", acks(), 0);
    reset = 1'b1;
    step();
    chk("rm_idle", busy, 0);
    chk("rm_rdata", rdata, 0);
    chk("rm_addr", mem_addr, 0);
    chk("rm_acks3", acks(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
